// File: rtl/vga_rx_monitor.sv
// Receive-side VGA timing monitor: recovers line/frame timing from sync edges, reports totals,
// lock state, active-pixel coordinates and a per-frame pixel checksum.
module vga_rx_monitor #(
   parameter int unsigned SYNC_POL = 0,
   parameter int unsigned H_START  = 144,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned V_START  = 35,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned CNT_W    = 12
) (
   input  logic             iClk,
   input  logic             iNRst,
   input  logic             iPixEn,
   input  logic             iHSync,
   input  logic             iVSync,
   input  logic [7:0]       iRGB,
   output logic             oPixValid,
   output logic [CNT_W-1:0] oPixX,
   output logic [CNT_W-1:0] oPixY,
   output logic [7:0]       oPixData,
   output logic [CNT_W-1:0] oHTotal,
   output logic [CNT_W-1:0] oVTotal,
   output logic [31:0]      oFrameSum,
   output logic [19:0]      oPixCount,
   output logic             oFrameDone,
   output logic             oLocked,
   output logic             oSyncLost
);

   localparam logic [CNT_W-1:0] CntMax  = '1;
   localparam logic             SyncLvl = (SYNC_POL != 0);

   typedef enum logic [1:0] {StSearch, StMeasure, StCheck, StLocked} state_e;

   // Input stage
   logic       pix_en_q, hs_q, vs_q;
   logic [7:0] rgb_q;

   always_ff @(posedge iClk or negedge iNRst) begin
      if (!iNRst) begin
         pix_en_q <= 1'b0;
         hs_q     <= 1'b0;
         vs_q     <= 1'b0;
         rgb_q    <= '0;
      end else begin
         pix_en_q <= iPixEn;
         hs_q     <= iHSync;
         vs_q     <= iVSync;
         rgb_q    <= iRGB;
      end
   end

   // Timing recovery stage
   logic             hs_prev_q, hs_prev_d;
   logic             vs_ls_q, vs_ls_d;
   logic [CNT_W-1:0] pix_idx_q, pix_idx_d;
   logic [CNT_W-1:0] line_idx_q, line_idx_d;
   logic [CNT_W-1:0] ref_len_q, ref_len_d;
   logic             have_len_q, have_len_d;
   logic             cons_q, cons_d;
   logic             ev_q, ev_d;
   logic             bnd_q, bnd_d;
   logic             sat_q, sat_d;
   logic             frame_ok_q, frame_ok_d;
   logic [CNT_W-1:0] frame_len_q, frame_len_d;
   logic [CNT_W-1:0] frame_lines_q, frame_lines_d;
   logic [7:0]       rgb_b_q, rgb_b_d;

   logic             hs_act, vs_act, line_start, frame_start, pix_sat, line_sat;
   logic [CNT_W-1:0] line_len;

   assign hs_act      = (hs_q == SyncLvl);
   assign vs_act      = (vs_q == SyncLvl);
   assign line_start  = pix_en_q & hs_act & ~hs_prev_q;
   assign frame_start = line_start & vs_act & ~vs_ls_q;
   assign line_len    = pix_idx_q + CNT_W'(1);
   // Saturation fires only on the increment that reaches the ceiling, so it pulses once
   assign pix_sat     = pix_en_q & ~line_start & (pix_idx_q == CntMax - CNT_W'(1));
   assign line_sat    = line_start & ~frame_start & (line_idx_q == CntMax - CNT_W'(1));

   always_comb begin
      hs_prev_d     = hs_prev_q;
      vs_ls_d       = vs_ls_q;
      pix_idx_d     = pix_idx_q;
      line_idx_d    = line_idx_q;
      ref_len_d     = ref_len_q;
      have_len_d    = have_len_q;
      cons_d        = cons_q;
      frame_ok_d    = frame_ok_q;
      frame_len_d   = frame_len_q;
      frame_lines_d = frame_lines_q;
      rgb_b_d       = rgb_b_q;
      ev_d          = pix_en_q;
      bnd_d         = frame_start;
      sat_d         = pix_sat | line_sat;
      if (pix_en_q) begin
         hs_prev_d = hs_act;
         rgb_b_d   = rgb_q;
         if (line_start) begin
            pix_idx_d = '0;
            vs_ls_d   = vs_act;
            if (frame_start) begin
               line_idx_d    = '0;
               frame_ok_d    = cons_q & (~have_len_q | (line_len == ref_len_q));
               frame_len_d   = line_len;
               frame_lines_d = line_idx_q + CNT_W'(1);
               cons_d        = 1'b1;
               have_len_d    = 1'b0;
            end else begin
               if (line_idx_q != CntMax) line_idx_d = line_idx_q + CNT_W'(1);
               if (!have_len_q) begin
                  ref_len_d  = line_len;
                  have_len_d = 1'b1;
               end else if (line_len != ref_len_q) begin
                  cons_d = 1'b0;
               end
            end
         end else if (pix_idx_q != CntMax) begin
            pix_idx_d = pix_idx_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge iClk or negedge iNRst) begin
      if (!iNRst) begin
         hs_prev_q     <= 1'b0;
         vs_ls_q       <= 1'b0;
         pix_idx_q     <= '0;
         line_idx_q    <= '0;
         ref_len_q     <= '0;
         have_len_q    <= 1'b0;
         cons_q        <= 1'b1;
         ev_q          <= 1'b0;
         bnd_q         <= 1'b0;
         sat_q         <= 1'b0;
         frame_ok_q    <= 1'b0;
         frame_len_q   <= '0;
         frame_lines_q <= '0;
         rgb_b_q       <= '0;
      end else begin
         hs_prev_q     <= hs_prev_d;
         vs_ls_q       <= vs_ls_d;
         pix_idx_q     <= pix_idx_d;
         line_idx_q    <= line_idx_d;
         ref_len_q     <= ref_len_d;
         have_len_q    <= have_len_d;
         cons_q        <= cons_d;
         ev_q          <= ev_d;
         bnd_q         <= bnd_d;
         sat_q         <= sat_d;
         frame_ok_q    <= frame_ok_d;
         frame_len_q   <= frame_len_d;
         frame_lines_q <= frame_lines_d;
         rgb_b_q       <= rgb_b_d;
      end
   end

   // Lock FSM, accumulation and output stage
   state_e           state_q, state_d;
   logic [31:0]      run_sum_q, run_sum_d;
   logic [19:0]      run_cnt_q, run_cnt_d;
   logic             pix_valid_q, pix_valid_d;
   logic [CNT_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic [7:0]       pix_data_q, pix_data_d;
   logic [CNT_W-1:0] htotal_q, htotal_d, vtotal_q, vtotal_d;
   logic [31:0]      frame_sum_q, frame_sum_d;
   logic [19:0]      pix_count_q, pix_count_d;
   logic             frame_done_q, frame_done_d;
   logic             locked_q, locked_d;
   logic             sync_lost_q, sync_lost_d;

   logic in_h, in_v, act, lost, match;

   assign in_h  = (32'(pix_idx_q) >= H_START) && (32'(pix_idx_q) < H_START + H_ACTIVE);
   assign in_v  = (32'(line_idx_q) >= V_START) && (32'(line_idx_q) < V_START + V_ACTIVE);
   assign act   = ev_q & in_h & in_v;
   assign lost  = sat_q & ~bnd_q;
   // Reference is the pair latched at the previous boundary
   assign match = frame_ok_q & (frame_len_q == htotal_q) & (frame_lines_q == vtotal_q);

   always_comb begin
      state_d      = state_q;
      run_sum_d    = (bnd_q | lost) ? 32'd0 : run_sum_q;
      run_cnt_d    = (bnd_q | lost) ? 20'd0 : run_cnt_q;
      pix_valid_d  = act;
      pix_x_d      = pix_x_q;
      pix_y_d      = pix_y_q;
      pix_data_d   = pix_data_q;
      htotal_d     = htotal_q;
      vtotal_d     = vtotal_q;
      frame_sum_d  = frame_sum_q;
      pix_count_d  = pix_count_q;
      frame_done_d = 1'b0;
      sync_lost_d  = 1'b0;
      if (act) begin
         pix_x_d    = pix_idx_q - CNT_W'(H_START);
         pix_y_d    = line_idx_q - CNT_W'(V_START);
         pix_data_d = rgb_b_q;
         if (!lost) begin
            run_sum_d = run_sum_d + {24'd0, rgb_b_q};
            run_cnt_d = run_cnt_d + 20'd1;
         end
      end
      if (bnd_q) begin
         if (state_q != StSearch) begin
            htotal_d     = frame_len_q;
            vtotal_d     = frame_lines_q;
            frame_sum_d  = run_sum_q;
            pix_count_d  = run_cnt_q;
            frame_done_d = 1'b1;
         end
         unique case (state_q)
            StSearch:  state_d = StMeasure;
            StMeasure: state_d = frame_ok_q ? StCheck : StMeasure;
            StCheck:   state_d = match ? StLocked : StMeasure;
            StLocked:  state_d = match ? StLocked : StMeasure;
         endcase
      end else if (lost) begin
         state_d     = StSearch;
         sync_lost_d = 1'b1;
      end
      locked_d = (state_d == StLocked);
   end

   always_ff @(posedge iClk or negedge iNRst) begin
      if (!iNRst) begin
         state_q      <= StSearch;
         run_sum_q    <= '0;
         run_cnt_q    <= '0;
         pix_valid_q  <= 1'b0;
         pix_x_q      <= '0;
         pix_y_q      <= '0;
         pix_data_q   <= '0;
         htotal_q     <= '0;
         vtotal_q     <= '0;
         frame_sum_q  <= '0;
         pix_count_q  <= '0;
         frame_done_q <= 1'b0;
         locked_q     <= 1'b0;
         sync_lost_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         run_sum_q    <= run_sum_d;
         run_cnt_q    <= run_cnt_d;
         pix_valid_q  <= pix_valid_d;
         pix_x_q      <= pix_x_d;
         pix_y_q      <= pix_y_d;
         pix_data_q   <= pix_data_d;
         htotal_q     <= htotal_d;
         vtotal_q     <= vtotal_d;
         frame_sum_q  <= frame_sum_d;
         pix_count_q  <= pix_count_d;
         frame_done_q <= frame_done_d;
         locked_q     <= locked_d;
         sync_lost_q  <= sync_lost_d;
      end
   end

   assign oPixValid  = pix_valid_q;
   assign oPixX      = pix_x_q;
   assign oPixY      = pix_y_q;
   assign oPixData   = pix_data_q;
   assign oHTotal    = htotal_q;
   assign oVTotal    = vtotal_q;
   assign oFrameSum  = frame_sum_q;
   assign oPixCount  = pix_count_q;
   assign oFrameDone = frame_done_q;
   assign oLocked    = locked_q;
   assign oSyncLost  = sync_lost_q;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor on a reduced 16x10 raster; one DUT per sync polarity,
// each pixel's expected outcome travels in a 3-deep pipe matching the 2-edge output latency.
module tb_vga_rx_monitor;

   localparam int unsigned HS   = 4;
   localparam int unsigned HA   = 8;
   localparam int unsigned VS   = 3;
   localparam int unsigned VA   = 4;
   localparam int unsigned CW   = 6;
   localparam int unsigned HTOT = 16;
   localparam int unsigned VTOT = 10;

   typedef struct packed {
      logic          act;
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic [7:0]    d;
      logic          bnd;
      logic          fd;
      logic          lk;
      logic          sl;
      logic [CW-1:0] ht;
      logic [CW-1:0] vt;
      logic [31:0]   sum;
      logic [19:0]   cnt;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pe, hs_line, vs_line;
   logic [7:0] rgb;

   logic          valid [2];
   logic [CW-1:0] px [2];
   logic [CW-1:0] py [2];
   logic [7:0]    pd [2];
   logic [CW-1:0] ht [2];
   logic [CW-1:0] vt [2];
   logic [31:0]   fsum [2];
   logic [19:0]   fcnt [2];
   logic          fdone [2];
   logic          lk [2];
   logic          lost [2];

   ent_t cur, p1, p2, p3;
   int   n_checks = 0;
   int   n_err = 0;
   logic [31:0] last_sum = '0;

   always #5 clk = ~clk;

   vga_rx_monitor #(
      .SYNC_POL(0), .H_START(HS), .H_ACTIVE(HA), .V_START(VS), .V_ACTIVE(VA), .CNT_W(CW)
   ) u_dut_lo (
      .iClk(clk), .iNRst(rst_n), .iPixEn(pe), .iHSync(~hs_line), .iVSync(~vs_line), .iRGB(rgb),
      .oPixValid(valid[0]), .oPixX(px[0]), .oPixY(py[0]), .oPixData(pd[0]),
      .oHTotal(ht[0]), .oVTotal(vt[0]), .oFrameSum(fsum[0]), .oPixCount(fcnt[0]),
      .oFrameDone(fdone[0]), .oLocked(lk[0]), .oSyncLost(lost[0])
   );

   vga_rx_monitor #(
      .SYNC_POL(1), .H_START(HS), .H_ACTIVE(HA), .V_START(VS), .V_ACTIVE(VA), .CNT_W(CW)
   ) u_dut_hi (
      .iClk(clk), .iNRst(rst_n), .iPixEn(pe), .iHSync(hs_line), .iVSync(vs_line), .iRGB(rgb),
      .oPixValid(valid[1]), .oPixX(px[1]), .oPixY(py[1]), .oPixData(pd[1]),
      .oHTotal(ht[1]), .oVTotal(vt[1]), .oFrameSum(fsum[1]), .oPixCount(fcnt[1]),
      .oFrameDone(fdone[1]), .oLocked(lk[1]), .oSyncLost(lost[1])
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1 <= '0;
         p2 <= '0;
         p3 <= '0;
      end else begin
         p1 <= cur;
         p2 <= p1;
         p3 <= p2;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 2; i++) begin
            if (p3.act || valid[i])
               chk($sformatf("pix_valid[%0d]", i), 64'(valid[i]), 64'(p3.act));
            if (p3.act)
               chk($sformatf("pix_xyd[%0d]", i), 64'({px[i], py[i], pd[i]}),
                   64'({p3.x, p3.y, p3.d}));
            if (p3.bnd || p3.sl || fdone[i])
               chk($sformatf("frame_done[%0d]", i), 64'(fdone[i]), 64'(p3.fd));
            if (p3.fd) begin
               chk($sformatf("frame_sum[%0d]", i), 64'(fsum[i]), 64'(p3.sum));
               chk($sformatf("pix_count[%0d]", i), 64'(fcnt[i]), 64'(p3.cnt));
            end
            if (p3.fd || p3.sl)
               chk($sformatf("totals[%0d]", i), 64'({ht[i], vt[i]}), 64'({p3.ht, p3.vt}));
            if (p3.bnd || p3.sl)
               chk($sformatf("locked[%0d]", i), 64'(lk[i]), 64'(p3.lk));
            if (p3.sl || lost[i])
               chk($sformatf("sync_lost[%0d]", i), 64'(lost[i]), 64'(p3.sl));
         end
      end
   end

   task automatic check_zero(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s_pix[%0d]", tag, i),
             64'({valid[i], px[i], py[i], pd[i], fdone[i], lk[i], lost[i]}), 64'd0);
         chk($sformatf("%s_tot[%0d]", tag, i), 64'({ht[i], vt[i], fcnt[i]}), 64'd0);
         chk($sformatf("%s_sum[%0d]", tag, i), 64'(fsum[i]), 64'd0);
      end
   endtask

   // One strobed pixel followed by one ignored cycle carrying random garbage
   task automatic put_pix(input logic h, input logic v, input logic [7:0] d, input ent_t e);
      @(negedge clk);
      pe      = 1'b1;
      hs_line = h;
      vs_line = v;
      rgb     = d;
      cur     = e;
      @(negedge clk);
      pe      = 1'b0;
      hs_line = 1'($urandom);
      vs_line = 1'($urandom);
      rgb     = 8'($urandom);
      cur     = '0;
   endtask

   // mode 0: constant 0x55; mode 1: active pixels carry X, blanking carries 0xAA
   task automatic send_frame(input int mode, input int bad_line, input int n_lines,
                             input logic fd, input logic lkx);
      for (int v = 0; v < n_lines; v++) begin
         int len;
         len = (v == bad_line) ? int'(HTOT) + 1 : int'(HTOT);
         for (int h = 0; h < len; h++) begin
            ent_t       e;
            logic [7:0] d;
            e     = '0;
            e.act = (h >= int'(HS)) && (h < int'(HS + HA)) && (v >= int'(VS)) &&
                    (v < int'(VS + VA));
            e.x   = CW'(h - int'(HS));
            e.y   = CW'(v - int'(VS));
            d     = (mode == 0) ? 8'h55 : (e.act ? 8'(h - int'(HS)) : 8'hAA);
            e.d   = d;
            if (v == 0 && h == 0) begin
               e.bnd = 1'b1;
               e.fd  = fd;
               e.lk  = lkx;
               e.ht  = CW'(HTOT);
               e.vt  = CW'(VTOT);
               e.sum = last_sum;
               e.cnt = 20'(HA * VA);
            end
            put_pix(h < 2, v < 2, d, e);
         end
      end
      // 32 * 0x55 = 2720; 4 lines * (0+1+..+7) = 112
      last_sum = (mode == 0) ? 32'd2720 : 32'd112;
   endtask

   // Line start, then HSync held inactive until the pixel counter saturates
   task automatic send_stall();
      ent_t e;
      e = '0;
      put_pix(1'b1, 1'b0, 8'h55, e);
      for (int k = 1; k <= 70; k++) begin
         e = '0;
         if (k == 63) begin
            e.sl = 1'b1;
            e.lk = 1'b0;
            e.ht = CW'(HTOT);
            e.vt = CW'(VTOT);
         end
         put_pix(1'b0, 1'b0, 8'h55, e);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      pe      = 1'b0;
      hs_line = 1'b0;
      vs_line = 1'b0;
      rgb     = '0;
      cur     = '0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;

      send_frame(0, -1, 10, 1'b0, 1'b0);
      send_frame(1, -1, 10, 1'b1, 1'b0);
      send_frame(0, -1, 10, 1'b1, 1'b1);
      send_frame(1, 5, 10, 1'b1, 1'b1);
      send_frame(0, -1, 10, 1'b1, 1'b0);
      send_frame(0, -1, 10, 1'b1, 1'b0);
      send_frame(0, -1, 10, 1'b1, 1'b1);
      send_stall();
      send_frame(1, -1, 10, 1'b0, 1'b0);
      send_frame(0, -1, 10, 1'b1, 1'b0);
      send_frame(0, -1, 10, 1'b1, 1'b1);
      send_frame(0, -1, 5, 1'b1, 1'b1);

      rst_n = 1'b0;
      #1;
      check_zero("midrst");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      send_frame(0, -1, 10, 1'b0, 1'b0);
      send_frame(1, -1, 10, 1'b1, 1'b0);
      send_frame(0, -1, 10, 1'b1, 1'b1);
      repeat (8) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/vga_rx_monitor.md
# vga_rx_monitor

Receive-side counterpart of the VGA timing generator. It samples the HSync, VSync and 8-bit RGB stream that the generator drives, and recovers line and frame timing from the sync edges. It reports measured totals, a lock flag, per-pixel coordinates and a per-frame pixel checksum. It sits beside VGA_Top in simulation and on-chip self-test, and closes the loop on the generated video.

## Interface
- SYNC_POL, 0, active sync level (0 = active-low syncs)
- H_START, 144, pixel index (from line start) of first active pixel
- H_ACTIVE, 640, active pixels per line
- V_START, 35, line index (from frame start) of first active line
- V_ACTIVE, 480, active lines per frame
- CNT_W, 12, width of pixel/line counters and totals
- iClk  in  1  system clock; one clock domain throughout
- iNRst  in  1  asynchronous active-low reset
- iPixEn  in  1  pixel strobe; inputs are valid only on cycles with iPixEn=1
- iHSync, iVSync  in  1 each  sync inputs from the generator
- iRGB  in  8  pixel data (3-3-2)
- oPixValid  out  1  one-cycle pulse per active pixel
- oPixX, oPixY  out  CNT_W each  active-area coordinates (0-based)
- oPixData  out  8  active pixel value
- oHTotal, oVTotal  out  CNT_W each  pixels/line and lines/frame, latched per frame
- oFrameSum  out  32  sum of iRGB over the active area of the last frame
- oPixCount  out  20  active pixels counted in the last frame
- oFrameDone  out  1  one-cycle pulse when the frame outputs update
- oLocked  out  1  timing stable
- oSyncLost  out  1  one-cycle pulse on counter saturation

## Operation
- Input stage: iHSync, iVSync, iRGB and iPixEn are registered every clock. All processing occurs only on cycles where the registered pixel strobe is 1.
- Sync "active" means input == SYNC_POL.
- Line start: HSync goes inactive→active between consecutive strobed samples. The pixel carrying this edge has index 0.
- Pixel index: 0 on a line start, otherwise previous index + 1. It saturates at 2^CNT_W−1.
- Line length: at every line start, line length = previous index + 1.
- Frame boundary: a line start where VSync is active and VSync was inactive at the previous line start. That line has index 0. Other line starts increment the line index, saturating at 2^CNT_W−1.
- Active pixel: pixel index in [H_START, H_START+H_ACTIVE) and line index in [V_START, V_START+V_ACTIVE).
  - Emits oPixValid with X = pixel−H_START, Y = line−V_START, oPixData = RGB.
  - Adds RGB to the running sum, zero-extended, wrapping mod 2^32.
  - Increments the running count.
- Consistency flag per frame: all line lengths completed in the frame are equal. The first length is measured at the frame's second line start; the last is measured at the closing boundary.
- Lock FSM, evaluated only at frame boundaries (the reference is the latched oHTotal/oVTotal):
  - SEARCH → MEASURE unconditionally.
  - MEASURE: latch totals; → CHECK if consistent, else stay in MEASURE.
  - CHECK: → LOCKED if consistent and totals equal the reference, else → MEASURE (reference re-latched).
  - LOCKED: stay on match. On mismatch or inconsistency → MEASURE and deassert oLocked.
- At each boundary outside SEARCH:
  - Latch oFrameSum, oPixCount, oHTotal and oVTotal.
  - Pulse oFrameDone.
  - Clear the running sum and count.
- Saturation of either counter:
  - Pulse oSyncLost and go to SEARCH.
  - Deassert oLocked; clear running sum and count.
  - Latched outputs are held.
- Simultaneous saturation and frame boundary: the boundary wins, because the counter resets.

## Timing
- Reset values:
  - All outputs 0.
  - FSM in SEARCH; counters, running sum/count and prior-sync history cleared.
- Reset is effective immediately and asynchronously, including mid-frame. After release, the block waits for a full frame in SEARCH.
- Pixel presented at edge n with iPixEn=1: oPixValid/X/Y/Data are valid after edge n+2, high for exactly one clock.
- Frame boundary pixel presented at edge n: oFrameDone, latched totals, sum/count and oLocked changes all appear after edge n+2 in the same cycle.
- oSyncLost uses the same 2-clock latency.
- Cycles with iPixEn=0 are ignored completely: no counting and no edge detection against them.
- Lock timing: oLocked rises at the 3rd frame boundary after reset with clean timing. The first oFrameDone is at the 2nd boundary.

## Test plan
- Clean 640x480 stream (HTotal 800, VTotal 525, 96/48 H, 2/33 V, iPixEn every 4th clock), constant RGB 0x55 → oFrameDone at boundaries 2, 3, …; oHTotal=800, oVTotal=525, oPixCount=307200, oFrameSum=0x018E7000; oLocked=1 after 3rd boundary.
- RGB = pixel X mod 256 → first oPixValid has X=0, Y=0, data 0x00, exactly 144 pixels after line start on line 35; last has X=639, Y=479.
- Locked, then one frame with an 801-pixel line → oLocked drops at that frame's boundary; it re-asserts two clean boundaries later.
- HSync held inactive for 4096 pixels → oSyncLost pulse, oLocked=0, FSM back to SEARCH; previous totals still on outputs.
- Assert iNRst low mid-frame while locked → all outputs 0 immediately; after release no oFrameDone until the 2nd boundary.
- SYNC_POL=1 with inverted syncs → identical results to the first scenario.
